// File: rtl/ranging_pkg.sv
// ranging_pkg
// Shared types and default timing for the ultrasonic ranging sequencer.
//   state_e     : sequencer FSM states (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF)
//   err_code_e  : error codes reported on err_code
//   *_DEF       : default timing constants for a 12 MHz clock
//   sat_inc     : 32-bit saturating increment used by all counters
package ranging_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_NO_ECHO    = 2'd1,
        ERR_OVER_RANGE = 2'd2,
        ERR_STUCK_HIGH = 2'd3
    } err_code_e;

    localparam int unsigned TRIG_CYCLES_DEF   = 120;     // 10 us
    localparam int unsigned RISE_TIMEOUT_DEF  = 24000;   // 2 ms
    localparam int unsigned ECHO_MAX_DEF      = 456000;  // 38 ms
    localparam int unsigned PERIOD_CYCLES_DEF = 720000;  // 60 ms

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync
// Brings the asynchronous sensor echo into the clk domain and derives edges.
//   clk       in  : system clock
//   rst       in  : synchronous active-high reset
//   echo      in  : raw echo pin, asynchronous
//   echo_s    out : echo after a 2-FF synchronizer (2-cycle latency)
//   echo_rise out : echo_s is 1 this cycle and was 0 the cycle before
//   echo_fall out : echo_s is 0 this cycle and was 1 the cycle before
// Both edges see the same latency, so widths measured between them are exact.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic echo_s,
    output logic echo_rise,
    output logic echo_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign echo_s    = sync_q;
    assign echo_rise = sync_q & ~prev_q;
    assign echo_fall = ~sync_q & prev_q;

endmodule

// File: rtl/ranging_sequencer.sv
// ranging_sequencer
// Runs the ultrasonic ranger trigger/echo cycle: issues the trigger pulse,
// times the synchronized echo, enforces the measurement period and reports
// either one validated echo width or an error per measurement.
//
// Ports
//   clk          in     : system clock (12 MHz)
//   rst          in     : synchronous active-high reset
//   enable       in     : continuous ranging while high
//   start        in     : one-shot request, only looked at in IDLE
//   echo         in     : raw sensor echo, asynchronous
//   trig         out    : sensor trigger
//   busy         out    : high whenever the FSM is not IDLE
//   echo_cycles  out 32 : last accepted echo width, held between results
//   result_valid out    : one-cycle pulse when echo_cycles updates
//   err_valid    out    : one-cycle pulse on a failed measurement
//   err_code     out 2  : last error (err_code_e), held until next error/reset
//   dbg_state    out 3  : current FSM state for observation
//
// Build option: RANGE_AVG_EN -- when defined, results are averaged over four
// consecutive successes (34-bit sum, truncated >>2); any error restarts the
// average. When undefined every success is reported directly.
module ranging_sequencer
    import ranging_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES   = TRIG_CYCLES_DEF,
    parameter int unsigned RISE_TIMEOUT  = RISE_TIMEOUT_DEF,
    parameter int unsigned ECHO_MAX      = ECHO_MAX_DEF,
    parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic [31:0] echo_cycles,
    output logic        result_valid,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [2:0]  dbg_state
);

    logic echo_s;
    logic echo_rise;
    logic echo_fall;

    echo_sync u_echo_sync (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo),
        .echo_s    (echo_s),
        .echo_rise (echo_rise),
        .echo_fall (echo_fall)
    );

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;        // trigger length, rise timeout, echo width
    logic [31:0] period_q, period_d;  // cycles since the current trigger rise
    logic        trig_q;
    logic [31:0] echo_cycles_q, echo_cycles_d;
    logic        result_valid_q, result_valid_d;
    logic        err_valid_q;
    err_code_e   err_code_q, err_code_d;

    logic        success;
    logic        fail;
    err_code_e   fail_code;

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = sat_inc(cnt_q);
        period_d  = sat_inc(period_q);
        success   = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (enable || start) begin
                    cnt_d    = '0;
                    // Cleared here too so a stuck-high holdoff lasts a full period.
                    period_d = '0;
                    if (echo_s) begin
                        state_d   = ST_HOLDOFF;
                        fail      = 1'b1;
                        fail_code = ERR_STUCK_HIGH;
                    end else begin
                        state_d = ST_TRIG;
                    end
                end
            end
            ST_TRIG: begin
                if (cnt_q == 32'(TRIG_CYCLES - 1)) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RISE: begin
                // A rise in the timeout cycle still counts as a rise.
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = 32'd1;
                end else if (cnt_q >= 32'(RISE_TIMEOUT - 1)) begin
                    state_d   = ST_HOLDOFF;
                    fail      = 1'b1;
                    fail_code = ERR_NO_ECHO;
                end
            end
            ST_MEASURE: begin
                if (!echo_s) begin
                    cnt_d = cnt_q;
                end
                // A fall coinciding with ECHO_MAX is a valid result.
                if (echo_fall) begin
                    state_d = ST_HOLDOFF;
                    success = 1'b1;
                end else if (cnt_q >= 32'(ECHO_MAX)) begin
                    state_d   = ST_HOLDOFF;
                    fail      = 1'b1;
                    fail_code = ERR_OVER_RANGE;
                end
            end
            ST_HOLDOFF: begin
                if (period_q >= 32'(PERIOD_CYCLES - 1)) begin
                    state_d = enable ? ST_TRIG : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every trigger starts a fresh period and a fresh trigger count, which
        // keeps continuous-mode trigger rises exactly PERIOD_CYCLES apart.
        if (state_d == ST_TRIG && state_q != ST_TRIG) begin
            period_d = '0;
            cnt_d    = '0;
        end
    end

    // ------------------------------------------------------------------
    // Result path
    // ------------------------------------------------------------------
`ifdef RANGE_AVG_EN
    logic [33:0] acc_q, acc_d;
    logic [1:0]  nsucc_q, nsucc_d;
    logic [33:0] acc_sum;

    always_comb begin
        acc_d          = acc_q;
        nsucc_d        = nsucc_q;
        echo_cycles_d  = echo_cycles_q;
        result_valid_d = 1'b0;
        acc_sum        = acc_q + {2'b00, cnt_q};
        if (fail) begin
            acc_d   = '0;
            nsucc_d = '0;
        end else if (success) begin
            if (nsucc_q == 2'd3) begin
                echo_cycles_d  = acc_sum[33:2];
                result_valid_d = 1'b1;
                acc_d          = '0;
                nsucc_d        = '0;
            end else begin
                acc_d   = acc_sum;
                nsucc_d = nsucc_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            nsucc_q <= '0;
        end else begin
            acc_q   <= acc_d;
            nsucc_q <= nsucc_d;
        end
    end
`else
    always_comb begin
        echo_cycles_d  = success ? cnt_q : echo_cycles_q;
        result_valid_d = success;
    end
`endif

    always_comb begin
        err_code_d = fail ? fail_code : err_code_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            trig_q         <= 1'b0;
            echo_cycles_q  <= '0;
            result_valid_q <= 1'b0;
            err_valid_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            trig_q         <= (state_d == ST_TRIG);
            echo_cycles_q  <= echo_cycles_d;
            result_valid_q <= result_valid_d;
            err_valid_q    <= fail;
            err_code_q     <= err_code_d;
        end
    end

    assign trig         = trig_q;
    assign busy         = (state_q != ST_IDLE);
    assign echo_cycles  = echo_cycles_q;
    assign result_valid = result_valid_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/ranging_sequencer.md
# ranging_sequencer

Owns the ultrasonic ranger's trigger/echo cycle. It issues the trigger pulse and synchronizes and times the echo. It enforces the inter-measurement period, detects missing or over-range echoes, and delivers one validated echo width per measurement to the reading/history logic. It sits between the `echo`/`trig` pins and the inch-conversion and history stage, in the `clk` (12 MHz oscillator) domain.

## Interface
- `TRIG_CYCLES`, default 120, trigger high time in cycles (10 µs).
- `RISE_TIMEOUT`, default 24000, maximum cycles from trigger fall to echo rise (2 ms).
- `ECHO_MAX`, default 456000, maximum echo-high cycles before the measurement is over-range (38 ms).
- `PERIOD_CYCLES`, default 720000, trigger-rise to trigger-rise spacing in continuous mode (60 ms). Must exceed `TRIG_CYCLES+RISE_TIMEOUT+ECHO_MAX+4`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: continuous ranging while high.
- `start` in 1: one-shot request; sampled only in IDLE.
- `echo` in 1: raw sensor echo, asynchronous to `clk`.
- `trig` out 1: sensor trigger.
- `busy` out 1: high in every state except IDLE.
- `echo_cycles` out 32: last accepted echo width; held between results.
- `result_valid` out 1: one-cycle pulse when `echo_cycles` updates.
- `err_valid` out 1: one-cycle pulse on a failed measurement.
- `err_code` out 2: 0 none, 1 NO_ECHO, 2 OVER_RANGE, 3 STUCK_HIGH; held until the next error or reset.

## Operation
- `echo` passes through a 2-FF synchronizer, giving `echo_s`; rise/fall come from a third registered copy.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: if `enable` or `start` is high and `echo_s`=0, go to TRIG. If `echo_s`=1 at that moment, pulse `err_valid` with STUCK_HIGH and go to HOLDOFF.
- TRIG: `trig`=1 for exactly `TRIG_CYCLES` cycles. The period counter clears on entry, then goes to WAIT_RISE.
- WAIT_RISE: on `echo_s` rise, go to MEASURE with the width counter at 1. After `RISE_TIMEOUT` cycles without a rise, go to HOLDOFF with NO_ECHO.
- MEASURE: the width counter increments each cycle `echo_s`=1. On fall, go to HOLDOFF; the counter value is the width.
  - If the counter reaches `ECHO_MAX` while still high, go to HOLDOFF with OVER_RANGE.
- HOLDOFF: wait until the period counter equals `PERIOD_CYCLES-1`.
  - If `enable`=1, go directly to TRIG.
  - Otherwise go to IDLE. A `start` that arrives during a measurement is ignored and is not queued.
- If `enable` drops mid-measurement, the current measurement completes and then returns to IDLE.
- Counters saturate and never wrap. Widths use unsigned 32-bit arithmetic.
- Precedence: a rise and timeout in the same cycle count as a rise; a fall and `ECHO_MAX` in the same cycle count as a fall (valid result).

## Timing
- Reset values: `trig`=0, `busy`=0, `echo_cycles`=0, `result_valid`=0, `err_valid`=0, `err_code`=0, state IDLE, all counters 0. Reset mid-measurement drops `trig` on the next edge.
- `trig` rises 1 cycle after the IDLE decision cycle.
- Echo sync latency is 2 cycles. Widths are exact in cycles; both edges carry the same latency.
- `result_valid` and `echo_cycles` update 1 cycle after the falling edge is detected.
- `err_valid` pulses in the cycle HOLDOFF is entered.
- Continuous mode: trigger rises are exactly `PERIOD_CYCLES` apart.

## Configuration
- `RANGE_AVG_EN` defined:
  - Each successful width is added to a 34-bit accumulator.
  - On every 4th consecutive success, `echo_cycles` = sum>>2 (truncated) and `result_valid` pulses. Intermediate successes produce no pulse.
  - Any error or reset clears the accumulator and the success count.
- `RANGE_AVG_EN` undefined: every success updates `echo_cycles` and pulses `result_valid`.

## Structure
- `ranging_pkg` holds:
  - the state enum;
  - the `err_code` enum (ERR_NONE, ERR_NO_ECHO, ERR_OVER_RANGE, ERR_STUCK_HIGH);
  - the default timing constants.
- One sub-module, `echo_sync`: 2-FF synchronizer plus registered copy, with outputs `echo_s`, `echo_rise`, `echo_fall`.

## Test plan
All scenarios use `TRIG_CYCLES`=4, `RISE_TIMEOUT`=20, `ECHO_MAX`=100, `PERIOD_CYCLES`=200.
- Normal: `start` pulse; echo rises 10 cycles after `trig` falls and stays high 37 cycles → `trig` high 4 cycles, `result_valid` once, `echo_cycles`=37, `busy` returns low 200 cycles after `trig` rise.
- No echo: `enable`=1, echo held low → `err_valid` with `err_code`=1 every 200 cycles, `echo_cycles` unchanged (0).
- Over-range: echo high for 150 cycles → `err_code`=2 at width 100, no `result_valid`, next `trig` still 200 cycles after the previous one.
- Stuck high: echo high before `start` → `err_code`=3, `trig` never asserts.
- Continuous with `enable` dropped mid-MEASURE: current result is reported, then IDLE with no further `trig`; `rst` asserted during MEASURE → all outputs at reset values on the next cycle.
- With `RANGE_AVG_EN`, widths 40, 41, 42, 44 → single `result_valid`, `echo_cycles`=41. A NO_ECHO after 2 samples restarts the count.
